fetch_stage: RTL

//  Instruction-fetch front end of the 5-stage pipeline. Owns the PC, drives the instruction bus
//  (one outstanding request), and presents {valid, pc, instr} to the fetch/decode pipeline register,

---
 rtl/fetch_stage_pkg.sv | 27 ++
 rtl/fetch_hold_buf.sv | 25 ++
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// fetch_data_t is the record held by the one-entry hold buffer;
// fetch_state_t is the fetch FSM encoding.
package fetch_stage_pkg;

  localparam logic [63:0] PC_RESET  = 64'h8000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic        exc_misal;
  } fetch_data_t;

  // Sequential next-instruction address; wraps modulo 2^64.
  function automatic logic [63:0] pc_plus4(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry hold buffer: keeps an instruction that returned while the
// downstream stage was stalled. Clear has priority over load.
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  fetch_data_t d,
  output fetch_data_t q
);

  // Buffer register with async reset; clear drops the entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues one outstanding
// instruction-bus request at a time and presents {valid, pc, instr} to the
// fetch/decode pipeline register. Honours stall and execute-stage redirect.
//
// Optional feature: define FETCH_MISALIGN_CHECK_EN to stop fetching from a
// misaligned PC and present a misaligned-PC exception until a redirect.
//
// Bus handshake: once ireq_valid rises, ireq_valid and ireq_addr stay stable
// until a cycle with iresp_data_ok; a request is never cancelled, and
// iresp_data_ok may arrive in the same cycle the request is first raised.
// dbg_state exposes the FSM state for observation.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] PC_RST  = PC_RESET,
  parameter logic [31:0] NOP_INS = NOP_INSTR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [63:0]  redirect_pc,
  output logic         ireq_valid,
  output logic [63:0]  ireq_addr,
  input  logic         iresp_data_ok,
  input  logic [31:0]  iresp_data,
  output logic         out_valid,
  output logic [63:0]  out_pc,
  output logic [31:0]  out_instr,
  output logic         out_exc_misal,
  output fetch_state_t dbg_state
);

  fetch_state_t state, state_next;
  logic [63:0]  pc, pc_next;
  logic [63:2]  req_addr;
  logic [63:0]  req_addr_full;
  logic         buf_load, buf_clear;
  fetch_data_t  buf_d, buf_q;

  assign req_addr_full = {req_addr, 2'b00};
  assign ireq_addr     = req_addr_full;
  assign dbg_state     = state;

  fetch_hold_buf u_hold_buf (
    .clk   (clk),
    .reset (reset),
    .load  (buf_load),
    .clear (buf_clear),
    .d     (buf_d),
    .q     (buf_q)
  );

  // State, PC and request-address registers; req_addr follows pc on every entry to REQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= REQ;
      pc       <= PC_RST;
      req_addr <= PC_RST[63:2];
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state_next == REQ) begin
        req_addr <= pc_next[63:2];
      end
    end
  end

  // Next-state, bus request and pipeline-register outputs; redirect always beats stall.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    ireq_valid    = 1'b0;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;
    buf_d         = '0;
    out_valid     = 1'b0;
    out_pc        = 64'd0;
    out_instr     = NOP_INS;
    out_exc_misal = 1'b0;
    unique case (state)
      REQ: begin
`ifdef FETCH_MISALIGN_CHECK_EN
        if (pc[1:0] != 2'b00) begin
          // Idle on a misaligned PC and report it until redirected.
          out_valid     = 1'b1;
          out_exc_misal = 1'b1;
          out_pc        = pc;
          if (redirect_valid) begin
            pc_next = redirect_pc;
          end
        end else begin
`else
        begin
`endif
          ireq_valid = 1'b1;
          if (iresp_data_ok) begin
            if (redirect_valid) begin
              // Response belongs to the wrong path: discard it.
              pc_next = redirect_pc;
            end else begin
              pc_next = pc_plus4(req_addr_full);
              if (!stall) begin
                out_valid = 1'b1;
                out_pc    = req_addr_full;
                out_instr = iresp_data;
              end else begin
                buf_load         = 1'b1;
                buf_d.valid      = 1'b1;
                buf_d.pc         = req_addr_full;
                buf_d.raw_instr  = iresp_data;
                buf_d.exc_misal  = 1'b0;
                state_next       = HOLD;
              end
            end
          end else if (redirect_valid) begin
            // Request still in flight and cannot be cancelled: wait it out.
            pc_next    = redirect_pc;
            state_next = FLUSH;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          buf_clear  = 1'b1;
          pc_next    = redirect_pc;
          state_next = REQ;
        end else begin
          out_valid     = buf_q.valid;
          out_pc        = buf_q.pc;
          out_instr     = buf_q.raw_instr;
          out_exc_misal = buf_q.exc_misal;
          if (!stall) begin
            buf_clear  = 1'b1;
            state_next = REQ;
          end
        end
      end
      FLUSH: begin
        ireq_valid = 1'b1;
        if (redirect_valid) begin
          pc_next = redirect_pc;
        end
        if (iresp_data_ok) begin
          state_next = REQ;
        end
      end
      default: begin
        state_next = REQ;
      end
    endcase
    // While reset is held, present the idle values regardless of inputs.
    if (reset) begin
      ireq_valid    = 1'b0;
      out_valid     = 1'b0;
      out_pc        = 64'd0;
      out_instr     = NOP_INS;
      out_exc_misal = 1'b0;
      buf_load      = 1'b0;
    end
  end

endmodule
